car_detect: RTL and testbench
=============================

# car_detect

Upstream stage of the parking-lot occupancy counter. Watches two photo sensors at the lot gate: `a` is the outer sensor and `b` the inner one. It synchronizes and debounces both, then tracks the blocking sequence with a direction FSM. For each complete car passage it emits a single-cycle `enter` or `exit` pulse, which feeds the counter's `enter`/`exit` inputs directly. Pedestrians, reversals that back fully out, and malformed sequences produce no count.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before a filtered sensor bit changes; legal range ≥1.
- `TIMEOUT_CYCLES`, default 1024: maximum cycles without a filtered input change while mid-sequence; used only with the timeout feature.
- `clk` input 1: single clock for the whole block.
- `Reset_n` input 1: one clock; reset is asynchronous and active-low.
- `a_raw` input 1: outer sensor, asynchronous; 1 = beam blocked.
- `b_raw` input 1: inner sensor, asynchronous; 1 = beam blocked.
- `enter` output 1: one-cycle pulse when a car completes an entry.
- `exit` output 1: one-cycle pulse when a car completes an exit.
- `busy` output 1: high whenever the FSM is not in IDLE.
- `err` output 1: one-cycle pulse on entry to ABORT.

## Operation
- Each sensor passes through a 2-flop synchronizer, then a filter. The filtered bit takes the synchronized value once that value has differed from the filtered bit for `DEBOUNCE_CYCLES` consecutive cycles. Any bounce restarts the count.
- The FSM acts on the filtered pair, written `{a,b}`. It has eight states:
  - IDLE
  - entry path: EN_A (10), EN_AB (11), EN_B (01)
  - exit path: EX_B (01), EX_BA (11), EX_A (10)
  - ABORT
- Entry transitions: IDLE→EN_A on 10; EN_A→EN_AB on 11; EN_AB→EN_B on 01; EN_B→IDLE on 00, which pulses `enter`.
- Exit transitions: IDLE→EX_B on 01; EX_B→EX_BA on 11; EX_BA→EX_A on 10; EX_A→IDLE on 00, which pulses `exit`.
- Reversal: a car may step back one position along its path (for example EN_AB→EN_A on 10, or EN_A→IDLE on 00). Backing out to IDLE this way emits no pulse and no `err`.
- An unchanged pair holds the current state.
- Illegal transitions go to ABORT with a one-cycle `err` pulse. Illegal means:
  - a two-step jump, e.g. EN_A seeing 01, or EN_AB seeing 00;
  - IDLE seeing 11.
- ABORT stays put until the pair reads 00, then returns to IDLE with no count.
- `enter` and `exit` are mutually exclusive and never high in consecutive cycles.
- Reset: FSM goes to IDLE. Synchronizers, filters and the timeout counter clear to 0. All outputs are 0. An asynchronous reset mid-sequence discards the partial passage; no pulse is emitted.

## Timing
- All outputs are registered.
- Latency from a raw change (stable from sampling edge 1) to the resulting FSM transition or pulse is `DEBOUNCE_CYCLES`+3 edges.
- `enter`/`exit`/`err` are high for exactly one cycle.
- `busy` changes in the same cycle as the state register.
- The minimum spacing between two counted passages is 4 filtered pair changes.

## Configuration
- Macro: `CAR_DETECT_TIMEOUT_EN`.
- Defined:
  - A counter runs while the FSM is in any state other than IDLE or ABORT.
  - It clears on every filtered pair change.
  - On reaching `TIMEOUT_CYCLES` the FSM goes to ABORT and pulses `err`.
  - The counter is `$clog2(TIMEOUT_CYCLES+1)` bits wide and saturates.
- Undefined: no counter is instantiated. A stalled sequence holds its state indefinitely. `TIMEOUT_CYCLES` is ignored.

## Structure
- `car_detect_pkg` holds:
  - the `state_t` enum for the eight states;
  - the `localparam` pair encodings `CLEAR`=00, `A_ONLY`=10, `B_ONLY`=01, `BOTH`=11.
- Sub-module `sensor_debounce` (synchronizer plus filter, parameter `DEBOUNCE_CYCLES`) is instantiated once per sensor.
- The FSM and timeout logic sit in `car_detect`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=2, with each raw level held 8 cycles.
- Reset mid-sequence: apply 10, then 11, assert `Reset_n`=0 → outputs 0 and `busy`=0 immediately. Release and apply 00 → no pulse.
- Entry: 00→10→11→01→00 → exactly one `enter` pulse, 5 edges after 00 is applied; `exit`=0 and `err`=0 throughout.
- Exit: 00→01→11→10→00 → exactly one `exit` pulse. Chaining this sequence into 3 back-to-back entries gives 3 `enter` pulses.
- Bounce: toggle `a_raw` every cycle for 10 cycles, then settle at 0 → filtered `a` never changes, `busy` stays 0, no pulses.
- Reversal and pedestrian cases:
  - 10→11→10→00 → no pulse, no `err`.
  - 10→00 (pedestrian) → no pulse.
  - 10→01→00 → one `err` pulse on the 01 step, ABORT, then IDLE; no count.
- Timeout, with the macro defined and `TIMEOUT_CYCLES`=16: hold 10 for 30 cycles → `err` pulse, ABORT. Release to 00 → IDLE, no count. Without the macro, the same stimulus gives `busy`=1 throughout and no `err`.

Source files
------------

// File: rtl/car_detect_pkg.sv
// car_detect_pkg: shared state enum and filtered sensor-pair encodings {a,b}
package car_detect_pkg;
    typedef enum logic [2:0] {IDLE, EN_A, EN_AB, EN_B, EX_B, EX_BA, EX_A, ABORT} state_t;
    localparam logic [1:0] CLEAR  = 2'b00;
    localparam logic [1:0] A_ONLY = 2'b10;
    localparam logic [1:0] B_ONLY = 2'b01;
    localparam logic [1:0] BOTH   = 2'b11;
endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: 2-flop synchronizer followed by a stability filter
// Ports: clk, Reset_n (async active-low), raw (async sensor), filt (debounced level)
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic Reset_n,
    input  logic raw,
    output logic filt
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic s1, s2;
    logic [CW-1:0] cnt;
    // filt follows s2 only after s2 has disagreed with it for DEBOUNCE_CYCLES
    // consecutive cycles; any agreement in between restarts the count
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            filt <= 1'b0;
            cnt  <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == filt) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                filt <= s2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/car_detect.sv
// car_detect: gate sensor direction FSM emitting enter/exit pulses per car passage
// Ports: clk, Reset_n (async active-low), a_raw/b_raw (outer/inner sensors, 1 = blocked),
//        enter/exit (one-cycle count pulses), busy (FSM not idle), err (one-cycle on ABORT entry)
// Optional: define CAR_DETECT_TIMEOUT_EN to abort sequences stalled for TIMEOUT_CYCLES
module car_detect
    import car_detect_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic clk,
    input  logic Reset_n,
    input  logic a_raw,
    input  logic b_raw,
    output logic enter,
    output logic exit,
    output logic busy,
    output logic err
);
    logic a, b;
    logic [1:0] p;
    state_t state, state_n;
    logic en_n, ex_n, er_n;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_a (.clk(clk), .Reset_n(Reset_n), .raw(a_raw), .filt(a));
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_b (.clk(clk), .Reset_n(Reset_n), .raw(b_raw), .filt(b));

    assign p = {a, b};

`ifdef CAR_DETECT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    logic [1:0] p_q;
    logic active, tmo;
    assign active = (state != IDLE) && (state != ABORT);
    assign tmo    = active && (p == p_q) && (tcnt == TW'(TIMEOUT_CYCLES));
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tcnt <= '0;
            p_q  <= CLEAR;
        end else begin
            p_q  <= p;
            tcnt <= (!active || p != p_q) ? '0 :
                    (tcnt == TW'(TIMEOUT_CYCLES)) ? tcnt : tcnt + TW'(1);
        end
    end
`else
    logic tmo;
    assign tmo = 1'b0;
`endif

    // Each path state accepts one step forward or back; anything farther is a jump -> ABORT
    always_comb begin
        state_n = state;
        en_n    = 1'b0;
        ex_n    = 1'b0;
        case (state)
            IDLE:  state_n = (p == A_ONLY) ? EN_A : (p == B_ONLY) ? EX_B : (p == BOTH) ? ABORT : IDLE;
            EN_A:  state_n = (p == BOTH)   ? EN_AB : (p == CLEAR)  ? IDLE : (p == B_ONLY) ? ABORT : EN_A;
            EN_AB: state_n = (p == B_ONLY) ? EN_B  : (p == A_ONLY) ? EN_A : (p == CLEAR)  ? ABORT : EN_AB;
            EN_B: begin
                state_n = (p == CLEAR) ? IDLE : (p == BOTH) ? EN_AB : (p == A_ONLY) ? ABORT : EN_B;
                en_n    = (p == CLEAR);
            end
            EX_B:  state_n = (p == BOTH)   ? EX_BA : (p == CLEAR)  ? IDLE : (p == A_ONLY) ? ABORT : EX_B;
            EX_BA: state_n = (p == A_ONLY) ? EX_A  : (p == B_ONLY) ? EX_B : (p == CLEAR)  ? ABORT : EX_BA;
            EX_A: begin
                state_n = (p == CLEAR) ? IDLE : (p == BOTH) ? EX_BA : (p == B_ONLY) ? ABORT : EX_A;
                ex_n    = (p == CLEAR);
            end
            ABORT: state_n = (p == CLEAR) ? IDLE : ABORT;
            default: state_n = IDLE;
        endcase
        if (tmo) state_n = ABORT;
        er_n = (state_n == ABORT) && (state != ABORT);
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            enter <= 1'b0;
            exit  <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            enter <= en_n;
            exit  <= ex_n;
            busy  <= (state_n != IDLE);
            err   <= er_n;
        end
    end
endmodule

// File: tb/tb_car_detect.sv
// tb_car_detect: table-driven directed test of car_detect with DEBOUNCE_CYCLES=2
module tb_car_detect;
    logic clk = 1'b0;
    logic Reset_n = 1'b0;
    logic a_raw = 1'b0;
    logic b_raw = 1'b0;
    logic enter, exit, busy, err;

    car_detect #(.DEBOUNCE_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .Reset_n(Reset_n), .a_raw(a_raw), .b_raw(b_raw),
        .enter(enter), .exit(exit), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ab;
        int en;
        int ex;
        int er;
        logic bz;
    } vec_t;

    vec_t tbl[$];
    int total = 0;
    int bad = 0;
    int n_en, n_ex, n_er, busy_seen;
    logic prev_pulse = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] ab, input int en, input int ex, input int er, input logic bz);
        vec_t v;
        v.ab = ab; v.en = en; v.ex = ex; v.er = er; v.bz = bz;
        tbl.push_back(v);
    endtask

    task automatic clr();
        n_en = 0; n_ex = 0; n_er = 0; busy_seen = 0;
    endtask

    // advance n cycles, sampling 1 time unit after each rising edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            n_en += int'(enter);
            n_ex += int'(exit);
            n_er += int'(err);
            busy_seen |= int'(busy);
            chk("pulse_excl", int'((enter && exit) || (prev_pulse && (enter || exit))), 0);
            prev_pulse = enter || exit;
        end
    endtask

    task automatic drive(input logic [1:0] ab);
        {a_raw, b_raw} = ab;
    endtask

    int lat;

    initial begin
        clr();
        #12;
        chk("rst_enter", int'(enter), 0);
        chk("rst_exit", int'(exit), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        Reset_n = 1'b1;
        step(4);

        // reset mid-sequence
        drive(2'b10); step(8);
        drive(2'b11); step(8);
        chk("mid_busy_before", int'(busy), 1);
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_outs", int'({enter, exit, err}), 0);
        prev_pulse = 1'b0;
        drive(2'b00);
        #20;
        @(posedge clk); #1;
        Reset_n = 1'b1;
        clr(); step(10);
        chk("mid_after_pulses", n_en + n_ex + n_er, 0);
        chk("mid_after_busy", busy_seen, 0);

        // table: entry, exit, three entries, reversal, pedestrian, malformed
        add(2'b00, 0, 0, 0, 0);
        add(2'b10, 0, 0, 0, 1); add(2'b11, 0, 0, 0, 1); add(2'b01, 0, 0, 0, 1); add(2'b00, 1, 0, 0, 0);
        add(2'b01, 0, 0, 0, 1); add(2'b11, 0, 0, 0, 1); add(2'b10, 0, 0, 0, 1); add(2'b00, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            add(2'b10, 0, 0, 0, 1); add(2'b11, 0, 0, 0, 1); add(2'b01, 0, 0, 0, 1); add(2'b00, 1, 0, 0, 0);
        end
        add(2'b10, 0, 0, 0, 1); add(2'b11, 0, 0, 0, 1); add(2'b10, 0, 0, 0, 1); add(2'b00, 0, 0, 0, 0);
        add(2'b10, 0, 0, 0, 1); add(2'b00, 0, 0, 0, 0);
        add(2'b10, 0, 0, 0, 1); add(2'b01, 0, 0, 1, 1); add(2'b11, 0, 0, 0, 1); add(2'b00, 0, 0, 0, 0);
        add(2'b11, 0, 0, 1, 1); add(2'b00, 0, 0, 0, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            clr();
            drive(tbl[i].ab);
            step(8);
            chk($sformatf("row%0d_enter", i), n_en, tbl[i].en);
            chk($sformatf("row%0d_exit", i), n_ex, tbl[i].ex);
            chk($sformatf("row%0d_err", i), n_er, tbl[i].er);
            chk($sformatf("row%0d_busy", i), int'(busy), int'(tbl[i].bz));
        end

        // entry latency: enter appears exactly 5 edges after 00 is applied
        drive(2'b10); step(8);
        drive(2'b11); step(8);
        drive(2'b01); step(8);
        clr();
        lat = 0;
        drive(2'b00);
        for (int k = 1; k <= 8; k++) begin
            step(1);
            if (enter && lat == 0) lat = k;
        end
        chk("entry_latency", lat, 5);
        chk("entry_latency_count", n_en, 1);

        // bounce on a_raw never reaches the filter
        clr();
        for (int k = 0; k < 10; k++) begin
            a_raw = ~a_raw;
            step(1);
        end
        a_raw = 1'b0;
        step(8);
        chk("bounce_busy", busy_seen, 0);
        chk("bounce_pulses", n_en + n_ex + n_er, 0);

        // stalled sequence
        clr();
        drive(2'b10);
        step(30);
        chk("stall_busy", int'(busy), 1);
`ifdef CAR_DETECT_TIMEOUT_EN
        chk("stall_err", n_er, 1);
`else
        chk("stall_err", n_er, 0);
`endif
        clr();
        drive(2'b00);
        step(8);
        chk("stall_release_busy", int'(busy), 0);
        chk("stall_release_pulses", n_en + n_ex + n_er, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
